z_unscan: RTL
=============

// Module: z_unscan
// PURPOSE
//  Inverse of the z-scan order generator: accepts an NxN block of samples that arrive in Z (Morton) order, each tagged with its zid.
//  Presents the block on the output in raster order, using a two-bank ping-pong buffer.
//  Sits downstream of any stage that emits data in z_scan order and feeds raster-order consumers; full-rate streaming with one bank filling while the other drains.
// PARAMETERS
//  DW     8  sample data width
//  LOG2N  3  log2 of block side; N=8, block = 64 samples, zid/addr width ZW = 2*LOG2N = 6
// PORTS
//  clk       in   1   single clock, all logic on rising edge
//  rst       in   1   synchronous, active-high reset
//  in_vld    in   1   input sample valid
//  in_rdy    out  1   input ready; transfer when in_vld & in_rdy
//  in_sob    in   1   start of block, qualified by the transfer
//  in_zid    in   ZW  Z-order index of the sample
//  in_data   in   DW  sample
//  out_vld   out  1   output sample valid
//  out_rdy   in   1   downstream ready; transfer when out_vld & out_rdy
//  out_sob   out  1   high with the first (raster 0) sample of a block
//  out_eob   out  1   high with the last (raster N*N-1) sample of a block
//  out_addr  out  ZW  raster index of the current output sample
//  out_data  out  DW  sample
//  err_sob   out  1   1-cycle pulse: in_sob arrived mid-block; partial block dropped
// BEHAVIOUR
//  Reset values: in_rdy=1, out_vld=0, out_sob=0, out_eob=0, out_addr=0, out_data=0, err_sob=0.
//  Reset state: both banks empty, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. Buffer contents are don't-care.
//  Address map: zid bit 2k = x[k], bit 2k+1 = y[k]. raster = {y,x} (y*N+x). For N=8: zid 6'b000011 -> raster 9; zid 6'b001100 -> raster 18.
//  Write side:
//   - On transfer, store in_data at bank[wr_bank][raster(in_zid)] and increment wr_cnt.
//   - Duplicate zids are not detected: last write wins.
//   - in_sob with wr_cnt!=0: pulse err_sob, discard the partial block, treat this sample as sample 0 (wr_cnt becomes 1).
//   - Transfer of sample N*N-1 (wr_cnt==N*N-1): set full[wr_bank] on that edge, toggle wr_bank, clear wr_cnt.
//   - in_rdy = !full[wr_bank] (combinational from registered state); low only when both banks are full.
//  Read side:
//   - out_vld = full[rd_bank].
//   - out_addr = rd_cnt; out_data = bank[rd_bank][rd_cnt] (combinational read of registered array).
//   - out_sob = out_vld & rd_cnt==0; out_eob = out_vld & rd_cnt==N*N-1.
//   - On transfer, increment rd_cnt. On the transfer with rd_cnt==N*N-1: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
//  Latency: first out_vld in the cycle after the edge that accepts the 64th input sample.
//   Steady state: 1 sample/clk in and out, no bubbles at block boundaries.
//  Simultaneous events:
//   - A write completing bank A and a read draining bank B in the same cycle both take effect.
//   - A read that frees a bank makes in_rdy high the next cycle (no same-cycle bypass).
//  out_rdy low holds out_addr/out_data/out_sob/out_eob stable.
//  rst mid-block drops all buffered and partial data; the next cycle matches reset state.
// STRUCTURE
//  z_scan_pkg: localparams N, ZW; function morton_to_raster(zid) (bit de-interleave).
//   Shared with z_scan so both ends use one bit mapping.
//  Sub-module z_unscan_bank: one N*N x DW register bank, write port (we, waddr, wdata) and combinational read port (raddr, rdata).
//   Instantiated twice.
//  Top holds wr/rd counters, bank pointers, full flags, err_sob and handshake logic.
// TESTING
//  1. Reset, then 64 samples with zid 0..63 in order, data=zid, sob on the first, out_rdy=1.
//     -> out_vld rises the cycle after the last accept. Outputs raster 0..63 with data=raster_to_morton(addr), e.g. addr 9 -> data 3. sob@0, eob@63.
//  2. Three back-to-back blocks, out_rdy=1.
//     -> in_rdy stays 1, outputs continuous, no idle cycle between blocks.
//  3. out_rdy=0 while feeding 128 samples.
//     -> in_rdy drops after the 128th accept. Releasing out_rdy drains bank 0 then bank 1; in_rdy returns 1 the cycle after bank 0's eob transfer.
//  4. in_sob at sample 20 of a block.
//     -> err_sob pulses once. The 20 earlier samples are dropped; the block completes 64 samples after the new sob.
//  5. rst asserted after 30 inputs and again mid-drain.
//     -> next cycle: out_vld=0, in_rdy=1. A fresh block then behaves as in test 1.
//  6. out_rdy random 50%, random zid permutation per block.
//     -> scoreboard matches raster order, and outputs hold stable while stalled.

Source files
------------

// File: rtl/z_scan_pkg.sv
// Shared constants and Morton/raster bit mapping for the z_scan / z_unscan pair.
// Both ends use this one function so the bit layout cannot drift apart.
package z_scan_pkg;

    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int ZW    = 2 * LOG2N;

    // zid bit 2k is x[k], bit 2k+1 is y[k]; raster index is {y, x}
    function automatic logic [ZW-1:0] morton_to_raster(input logic [ZW-1:0] zid);
        logic [LOG2N-1:0] x;
        logic [LOG2N-1:0] y;
        for (int k = 0; k < LOG2N; k++) begin
            x[k] = zid[2*k];
            y[k] = zid[2*k+1];
        end
        return {y, x};
    endfunction

endpackage

// File: rtl/z_unscan_bank.sv
// One N*N sample bank: synchronous write port, combinational read port.
// Contents are not reset; the top only presents them once a bank is full.
module z_unscan_bank #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/z_unscan.sv
// Z-order to raster reorder buffer: two ping-pong banks, one filling
// while the other drains, full rate on both sides.
module z_unscan
    import z_scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic          in_sob,
    input  logic [ZW-1:0] in_zid,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic          out_sob,
    output logic          out_eob,
    output logic [ZW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          err_sob
);

    localparam logic [ZW-1:0] LAST = {ZW{1'b1}};

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wr_bank;
    logic          rd_bank;
    logic [ZW-1:0] wr_cnt;
    logic [ZW-1:0] rd_cnt;
    logic [ZW-1:0] wr_idx;
    logic [ZW-1:0] waddr;
    logic          wr_xfer;
    logic          rd_xfer;
    logic          sob_restart;
    logic [DW-1:0] rdata [2];

    assign in_rdy      = !full[wr_bank];
    assign wr_xfer     = in_vld & in_rdy;
    assign sob_restart = wr_xfer & in_sob & (wr_cnt != '0);
    // A start-of-block always restarts the fill at sample 0
    assign wr_idx      = in_sob ? '0 : wr_cnt;
    assign waddr       = morton_to_raster(in_zid);

    assign out_vld  = full[rd_bank];
    assign rd_xfer  = out_vld & out_rdy;
    assign out_addr = rd_cnt;
    assign out_data = out_vld ? rdata[rd_bank] : '0;
    assign out_sob  = out_vld & (rd_cnt == '0);
    assign out_eob  = out_vld & (rd_cnt == LAST);

    // Fill and drain always target different banks, so both may land together
    always_comb begin
        full_nxt = full;
        if (wr_xfer && wr_idx == LAST) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_xfer && rd_cnt == LAST) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_sob <= 1'b0;
        end else begin
            full    <= full_nxt;
            err_sob <= sob_restart;
            if (wr_xfer) begin
                if (wr_idx == LAST) begin
                    wr_bank <= ~wr_bank;
                    wr_cnt  <= '0;
                end else begin
                    wr_cnt <= wr_idx + 1'b1;
                end
            end
            if (rd_xfer) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        z_unscan_bank #(
            .DW(DW),
            .AW(ZW)
        ) u_bank (
            .clk  (clk),
            .we   (wr_xfer && (wr_bank == 1'(b))),
            .waddr(waddr),
            .wdata(in_data),
            .raddr(rd_cnt),
            .rdata(rdata[b])
        );
    end

endmodule
